// File: rtl/vga_axil_regs_if.sv
// AXI4-Lite bus between the CPU master and the VGA register bank.
// Master drives requests and response-ready; slave drives readies and responses.
interface vga_axil_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/vga_axil_regs.sv
// AXI4-Lite register bank for VGA config; last word is read-only STATUS.
// Latency: bvalid/rvalid one cycle after the completing address/data handshake.
// Backpressure: responses held until bready/rready; request readies stay low until then.
module vga_axil_regs #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 8
) (
   input  logic                     clk,
   input  logic                     arst_n,
   vga_axil_if.slave                bus,
   input  logic [DATA_WIDTH-1:0]    status_i,
   output logic [NUM_REGS*32-1:0]   regs_o
);
   localparam int                IDX_W       = ADDR_WIDTH - 2;
   localparam int                NB          = DATA_WIDTH / 8;
   localparam logic [IDX_W-1:0]  STATUS_IDX  = IDX_W'(NUM_REGS - 1);
   localparam logic [IDX_W-1:0]  NUM_IDX     = IDX_W'(NUM_REGS);
   localparam logic [1:0]        RESP_OKAY   = 2'b00;
   localparam logic [1:0]        RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} wstate_t;
   typedef enum logic       {R_IDLE, R_RESP} rstate_t;

   wstate_t               wstate;
   rstate_t               rstate;
   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [IDX_W-1:0]      aw_idx_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [NB-1:0]         wstrb_q;

   logic                  aw_hs, w_hs, ar_hs, commit;
   logic [IDX_W-1:0]      wr_idx, ar_idx;
   logic [DATA_WIDTH-1:0] wr_dat, rd_dat;
   logic [NB-1:0]         wr_strb;
   logic                  unused_addr_bits;

   assign aw_hs  = bus.awvalid & bus.awready;
   assign w_hs   = bus.wvalid & bus.wready;
   assign ar_hs  = bus.arvalid & bus.arready;
   assign ar_idx = bus.araddr[ADDR_WIDTH-1:2];
   assign unused_addr_bits = ^{bus.awaddr[1:0], bus.araddr[1:0]};

   // Whichever half arrived first was latched; the other comes straight off the bus.
   assign wr_idx  = (wstate == W_HAVE_A) ? aw_idx_q : bus.awaddr[ADDR_WIDTH-1:2];
   assign wr_dat  = (wstate == W_HAVE_D) ? wdata_q  : bus.wdata;
   assign wr_strb = (wstate == W_HAVE_D) ? wstrb_q  : bus.wstrb;
   assign commit  = ((wstate == W_IDLE)   && aw_hs && w_hs) ||
                    ((wstate == W_HAVE_A) && w_hs) ||
                    ((wstate == W_HAVE_D) && aw_hs);

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wstate      <= W_IDLE;
         bus.awready <= 1'b1;
         bus.wready  <= 1'b1;
         bus.bvalid  <= 1'b0;
         bus.bresp   <= RESP_OKAY;
         aw_idx_q    <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else if (commit) begin
         for (int i = 0; i < NUM_REGS - 1; i++)
            if (wr_idx == IDX_W'(i))
               for (int b = 0; b < NB; b++)
                  if (wr_strb[b]) regs_q[i][8*b +: 8] <= wr_dat[8*b +: 8];
         bus.awready <= 1'b0;
         bus.wready  <= 1'b0;
         bus.bvalid  <= 1'b1;
         bus.bresp   <= (wr_idx < STATUS_IDX) ? RESP_OKAY : RESP_SLVERR;
         wstate      <= W_RESP;
      end else begin
         case (wstate)
            W_IDLE: begin
               if (aw_hs) begin
                  aw_idx_q    <= bus.awaddr[ADDR_WIDTH-1:2];
                  bus.awready <= 1'b0;
                  wstate      <= W_HAVE_A;
               end else if (w_hs) begin
                  wdata_q     <= bus.wdata;
                  wstrb_q     <= bus.wstrb;
                  bus.wready  <= 1'b0;
                  wstate      <= W_HAVE_D;
               end
            end
            W_RESP: begin
               if (bus.bready) begin
                  bus.bvalid  <= 1'b0;
                  bus.awready <= 1'b1;
                  bus.wready  <= 1'b1;
                  wstate      <= W_IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      rd_dat = '0;
      for (int i = 0; i < NUM_REGS; i++)
         if (ar_idx == IDX_W'(i)) rd_dat = (i == NUM_REGS - 1) ? status_i : regs_q[i];
   end

   // regs_q is sampled before any same-edge commit, so a colliding read sees the old value.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         rstate      <= R_IDLE;
         bus.arready <= 1'b1;
         bus.rvalid  <= 1'b0;
         bus.rdata   <= '0;
         bus.rresp   <= RESP_OKAY;
      end else begin
         case (rstate)
            R_IDLE: begin
               if (ar_hs) begin
                  bus.rdata   <= rd_dat;
                  bus.rresp   <= (ar_idx < NUM_IDX) ? RESP_OKAY : RESP_SLVERR;
                  bus.rvalid  <= 1'b1;
                  bus.arready <= 1'b0;
                  rstate      <= R_RESP;
               end
            end
            R_RESP: begin
               if (bus.rready) begin
                  bus.rvalid  <= 1'b0;
                  bus.arready <= 1'b1;
                  rstate      <= R_IDLE;
               end
            end
            default: rstate <= R_IDLE;
         endcase
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
      if (g == NUM_REGS - 1) begin : g_status
         assign regs_o[32*g +: 32] = '0;
      end else begin : g_rw
         assign regs_o[32*g +: 32] = regs_q[g];
      end
   end
endmodule

// File: tb/tb_vga_axil_regs.sv
// Directed bench for vga_axil_regs: vector table plus hand-written handshake sequences.
module tb_vga_axil_regs;
   logic         clk = 1'b0;
   logic         arst_n;
   logic [31:0]  status_i;
   logic [255:0] regs_o;
   int           n_pass = 0;
   int           n_total = 0;

   vga_axil_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   vga_axil_regs #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(8)) dut (
      .clk      (clk),
      .arst_n   (arst_n),
      .bus      (bus.slave),
      .status_i (status_i),
      .regs_o   (regs_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] dat;
      logic [3:0]  strb;
      logic [31:0] status;
      logic [1:0]  resp;
      logic [31:0] rdata;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output bit tmo);
      bit aw_done, w_done, aw_now, w_now;
      tmo = 1'b1;
      resp = 2'bxx;
      aw_done = 1'b0;
      w_done = 1'b0;
      bus.awaddr = a; bus.awvalid = 1'b1;
      bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
      bus.bready = 1'b1;
      for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
         aw_now = bus.awvalid && bus.awready;
         w_now  = bus.wvalid && bus.wready;
         step();
         if (aw_now) begin bus.awvalid = 1'b0; aw_done = 1'b1; end
         if (w_now)  begin bus.wvalid  = 1'b0; w_done  = 1'b1; end
      end
      bus.awvalid = 1'b0;
      bus.wvalid = 1'b0;
      if (aw_done && w_done)
         for (int n = 0; n < 20; n++) begin
            if (bus.bvalid) begin
               resp = bus.bresp;
               tmo = 1'b0;
               step();
               break;
            end
            step();
         end
   endtask

   task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                           output logic [1:0] resp, output bit tmo);
      bit done;
      tmo = 1'b1;
      d = 'x;
      resp = 2'bxx;
      done = 1'b0;
      bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b1;
      for (int n = 0; n < 20 && !done; n++) begin
         done = bus.arready;
         step();
      end
      bus.arvalid = 1'b0;
      if (done)
         for (int n = 0; n < 20; n++) begin
            if (bus.rvalid) begin
               d = bus.rdata;
               resp = bus.rresp;
               tmo = 1'b0;
               step();
               break;
            end
            step();
         end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  resp;
      logic [31:0] rd;
      bit          tmo;

      vecs[0]  = '{1'b0, 32'h04, 32'h0,        4'h0, 32'h0,      2'b00, 32'hDEADBEEF};
      vecs[1]  = '{1'b1, 32'h40, 32'h11111111, 4'hF, 32'h0,      2'b10, 32'h0};
      vecs[2]  = '{1'b1, 32'h1C, 32'h22222222, 4'hF, 32'h0,      2'b10, 32'h0};
      vecs[3]  = '{1'b0, 32'h40, 32'h0,        4'h0, 32'h0,      2'b10, 32'h0};
      vecs[4]  = '{1'b0, 32'h1C, 32'h0,        4'h0, 32'hA5A5,   2'b00, 32'hA5A5};
      vecs[5]  = '{1'b1, 32'h04, 32'h00CC0000, 4'h4, 32'h0,      2'b00, 32'h0};
      vecs[6]  = '{1'b0, 32'h04, 32'h0,        4'h0, 32'h0,      2'b00, 32'hDECCBEEF};
      vecs[7]  = '{1'b1, 32'h0C, 32'h00000055, 4'h0, 32'h0,      2'b00, 32'h0};
      vecs[8]  = '{1'b0, 32'h0C, 32'h0,        4'h0, 32'h0,      2'b00, 32'h0};
      vecs[9]  = '{1'b1, 32'h18, 32'hCAFEF00D, 4'hF, 32'h0,      2'b00, 32'h0};
      vecs[10] = '{1'b0, 32'h1A, 32'h0,        4'h0, 32'h0,      2'b00, 32'hCAFEF00D};
      vecs[11] = '{1'b0, 32'h1E, 32'h0,        4'h0, 32'h1234,   2'b00, 32'h1234};

      arst_n = 1'b0;
      status_i = '0;
      bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
      bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

      #100;
      chk("rst_awready", 32'(bus.awready), 32'd1);
      chk("rst_wready", 32'(bus.wready), 32'd1);
      chk("rst_arready", 32'(bus.arready), 32'd1);
      chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
      chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
      chk("rst_regs_lo", regs_o[31:0], 32'd0);
      chk("rst_regs_hi", regs_o[255:224], 32'd0);
      arst_n = 1'b1;
      step();

      // AW and W together: response one cycle later, reg visible after commit.
      bus.awaddr = 32'h4; bus.awvalid = 1'b1;
      bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF; bus.wvalid = 1'b1; bus.bready = 1'b1;
      step();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      chk("t2_bvalid", 32'(bus.bvalid), 32'd1);
      chk("t2_bresp", 32'(bus.bresp), 32'd0);
      chk("t2_awready_busy", 32'(bus.awready), 32'd0);
      chk("t2_regs1", regs_o[63:32], 32'hDEADBEEF);
      step();
      chk("t2_bvalid_done", 32'(bus.bvalid), 32'd0);
      chk("t2_awready_back", 32'(bus.awready), 32'd1);

      for (int i = 0; i < 12; i++) begin
         status_i = vecs[i].status;
         if (vecs[i].wr) begin
            axi_write(vecs[i].addr, vecs[i].dat, vecs[i].strb, resp, tmo);
            chk($sformatf("vec%0d_wr_tmo", i), 32'(tmo), 32'd0);
         end else begin
            axi_read(vecs[i].addr, rd, resp, tmo);
            chk($sformatf("vec%0d_rd_tmo", i), 32'(tmo), 32'd0);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
         end
         chk($sformatf("vec%0d_resp", i), 32'(resp), 32'(vecs[i].resp));
      end
      chk("tbl_status_slice", regs_o[255:224], 32'd0);
      chk("tbl_regs6", regs_o[223:192], 32'hCAFEF00D);

      // AW first, W three cycles later.
      bus.awaddr = 32'h8; bus.awvalid = 1'b1; bus.bready = 1'b1;
      step();
      bus.awvalid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("t3_awready_c%0d", c), 32'(bus.awready), 32'd0);
         chk($sformatf("t3_wready_c%0d", c), 32'(bus.wready), 32'd1);
         chk($sformatf("t3_bvalid_c%0d", c), 32'(bus.bvalid), 32'd0);
         step();
      end
      bus.wdata = 32'h12345678; bus.wstrb = 4'h3; bus.wvalid = 1'b1;
      step();
      bus.wvalid = 1'b0;
      chk("t3_bvalid", 32'(bus.bvalid), 32'd1);
      chk("t3_bresp", 32'(bus.bresp), 32'd0);
      chk("t3_regs2", regs_o[95:64], 32'h00005678);
      step();
      chk("t3_awready_back", 32'(bus.awready), 32'd1);

      // Backpressure on both responses; read finishes while write still waits.
      bus.bready = 1'b0; bus.rready = 1'b0;
      bus.awaddr = 32'h10; bus.awvalid = 1'b1;
      bus.wdata = 32'h0BADF00D; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
      step();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      bus.araddr = 32'h10; bus.arvalid = 1'b1;
      step();
      bus.arvalid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("t5_bvalid_c%0d", c), 32'(bus.bvalid), 32'd1);
         chk($sformatf("t5_bresp_c%0d", c), 32'(bus.bresp), 32'd0);
         chk($sformatf("t5_awready_c%0d", c), 32'(bus.awready), 32'd0);
         chk($sformatf("t5_wready_c%0d", c), 32'(bus.wready), 32'd0);
         chk($sformatf("t5_rvalid_c%0d", c), 32'(bus.rvalid), 32'd1);
         chk($sformatf("t5_rdata_c%0d", c), bus.rdata, 32'h0BADF00D);
         chk($sformatf("t5_arready_c%0d", c), 32'(bus.arready), 32'd0);
         step();
      end
      bus.rready = 1'b1;
      step();
      chk("t5_rvalid_done", 32'(bus.rvalid), 32'd0);
      chk("t5_arready_back", 32'(bus.arready), 32'd1);
      chk("t5_bvalid_still", 32'(bus.bvalid), 32'd1);
      bus.bready = 1'b1;
      step();
      chk("t5_bvalid_done", 32'(bus.bvalid), 32'd0);
      chk("t5_awready_back", 32'(bus.awready), 32'd1);

      // Write commit and read of the same register on one edge: read sees old value.
      bus.awaddr = 32'h10; bus.awvalid = 1'b1;
      bus.wdata = 32'h77777777; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
      bus.araddr = 32'h10; bus.arvalid = 1'b1;
      step();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
      chk("coll_rvalid", 32'(bus.rvalid), 32'd1);
      chk("coll_rdata_old", bus.rdata, 32'h0BADF00D);
      step();
      chk("coll_regs4_new", regs_o[159:128], 32'h77777777);

      // Reset while holding only an address: nothing commits afterwards.
      bus.awaddr = 32'h0; bus.awvalid = 1'b1;
      step();
      bus.awvalid = 1'b0;
      chk("t6_awready_held", 32'(bus.awready), 32'd0);
      arst_n = 1'b0;
      #2;
      chk("t6_rst_awready", 32'(bus.awready), 32'd1);
      chk("t6_rst_bvalid", 32'(bus.bvalid), 32'd0);
      #20;
      arst_n = 1'b1;
      step();
      bus.wdata = 32'hFFFFFFFF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
      step();
      bus.wvalid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("t6_bvalid_c%0d", c), 32'(bus.bvalid), 32'd0);
         step();
      end
      chk("t6_regs0", regs_o[31:0], 32'd0);
      chk("t6_regs1_cleared", regs_o[63:32], 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
